md_issue_ctrl: RTL

- Issue/stall controller for the pipeline's multiply/divide + HI/LO unit.
- Takes the md operation class in D and E stages; forwards start/move commands to the unit.
- Owns the latency counter and the D-stage stall.
- The unit becomes a plain datapath that captures its result on a commit pulse.

---
 rtl/md_issue_ctrl_pkg.sv | 34 +++
 rtl/md_issue_ctrl_if.sv | 28 ++
 rtl/md_issue_ctrl_lat_counter.sv | 25 ++
 rtl/md_issue_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and helpers for the multiply/divide issue controller.
// The md op code is laid out so that bit 0 marks a start and bit 2 marks a divide.
package md_issue_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MTHI  = 3'd2;
  localparam logic [2:0] MD_MULTU = 3'd3;
  localparam logic [2:0] MD_MTLO  = 3'd4;
  localparam logic [2:0] MD_DIV   = 3'd5;
  localparam logic [2:0] MD_DIVU  = 3'd7;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef enum logic {
    TYPE_MULT = 1'b0,
    TYPE_DIV  = 1'b1
  } md_type_e;

  function automatic logic is_start(input logic [2:0] op);
    return op[0];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline-side bundle of the md issue controller plus its FSM debug view.
import md_issue_ctrl_pkg::*;

// e_op is presented for exactly one cycle per E-stage instruction and carries no
// valid/ready pair; md_start != NONE is the only qualifier toward the unit, which
// cannot push back, so the pipeline must honour stall_d instead.
interface md_issue_ctrl_if;
  logic        d_md_use;
  logic [2:0]  e_op;
  logic [2:0]  md_start;
  logic        md_commit;
  logic        busy;
  logic        stall_d;
  logic        err;
  logic [31:0] stall_cnt;
  md_state_e   state;
  md_type_e    run_type;

  modport slave (
    input  d_md_use, e_op,
    output md_start, md_commit, busy, stall_d, err, stall_cnt, state, run_type
  );

  modport master (
    output d_md_use, e_op,
    input  md_start, md_commit, busy, stall_d, err, stall_cnt, state, run_type
  );
endinterface

// File: rtl/md_issue_ctrl_lat_counter.sv
// Latency down-counter: loads the busy length, counts down, flags the final cycle.
module md_issue_ctrl_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       tc
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign tc = (cnt_q == 4'd1);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/stall controller for the mult/div + HI/LO unit: forwards commands, times
// the operation, pulses the result commit and freezes D while the unit is busy.
import md_issue_ctrl_pkg::*;

module md_issue_ctrl #(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  md_issue_ctrl_if.slave  md
);

  localparam logic [3:0] MULT_LAT4 = 4'(MULT_LAT);
  localparam logic [3:0] DIV_LAT4  = 4'(DIV_LAT);

  md_state_e   state_q, state_d;
  md_type_e    type_q, type_d;
  logic        cnt_load;
  logic [3:0]  cnt_load_val;
  logic        cnt_dec;
  logic        cnt_tc;
  logic [2:0]  start;
  logic        commit;
  logic        err_set;
  logic        err_q;
  logic        busy;
  logic        stall;
  logic [31:0] stall_cnt_q;

  md_issue_ctrl_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= TYPE_MULT;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
    cnt_dec      = 1'b0;
    start        = MD_NONE;
    commit       = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start = md.e_op;
        if (is_start(md.e_op)) begin
          state_d      = ST_RUN;
          cnt_load     = 1'b1;
          type_d       = is_div(md.e_op) ? TYPE_DIV : TYPE_MULT;
          cnt_load_val = is_div(md.e_op) ? DIV_LAT4 : MULT_LAT4;
        end
      end
      ST_RUN: begin
        cnt_dec = 1'b1;
        // Anything reaching E while running slipped past stall_d: drop it, flag it.
        if (md.e_op != MD_NONE) begin
          err_set = 1'b1;
        end
        if (cnt_tc) begin
          // A reset landing on the final cycle aborts the op, so no commit.
          commit  = ~reset;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = md.d_md_use & (busy | is_start(md.e_op));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign md.md_start  = start;
  assign md.md_commit = commit;
  assign md.busy      = busy;
  assign md.stall_d   = stall;
  assign md.err       = err_q;
  assign md.stall_cnt = stall_cnt_q;
  assign md.state     = state_q;
  assign md.run_type  = type_q;

endmodule
